// File: rtl/regfile_param.sv
// Parametrised register file: two write ports (E, M; M wins a collision) and two registered read ports with stall.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-edge write data into the read registers.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int ID_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ID_W-1:0]        dstE,
  input  logic [DATA_W-1:0]      valE,
  input  logic [ID_W-1:0]        dstM,
  input  logic [DATA_W-1:0]      valM,
  input  logic [ID_W-1:0]        rA,
  input  logic [ID_W-1:0]        rB,
  input  logic                   stall,
  output logic [DATA_W-1:0]      valA,
  output logic [DATA_W-1:0]      valB,
  output logic [NREG*DATA_W-1:0] regs_flat,
  output logic                   wr_collide
);

  localparam logic [ID_W-1:0] RNONE = '1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] val_a_q, val_a_d;
  logic [DATA_W-1:0] val_b_q, val_b_d;
  logic              wr_collide_q, wr_collide_d;
  logic              we_e, we_m;

  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return (id != RNONE) && (int'(id) < NREG);
  endfunction

  // Out-of-range and RNONE IDs never match an implemented index, so they read as zero.
  function automatic logic [DATA_W-1:0] storage_read(input logic [ID_W-1:0] id);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) begin
      if (id == ID_W'(i)) r = regs_q[i];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ID_W-1:0] id);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we_m && (id == dstM)) return valM;
    if (we_e && (id == dstE)) return valE;
`endif
    return storage_read(id);
  endfunction

  assign we_e = id_in_range(dstE);
  assign we_m = id_in_range(dstM);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      // M is checked first so that it wins a same-register collision.
      if (we_m && (dstM == ID_W'(i))) begin
        regs_d[i] = valM;
      end else if (we_e && (dstE == ID_W'(i))) begin
        regs_d[i] = valE;
      end
    end
  end

  always_comb begin
    val_a_d      = val_a_q;
    val_b_d      = val_b_q;
    wr_collide_d = we_e && we_m && (dstE == dstM);
    if (!stall) begin
      val_a_d = read_port(rA);
      val_b_d = read_port(rB);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      val_a_q      <= '0;
      val_b_q      <= '0;
      wr_collide_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      val_a_q      <= val_a_d;
      val_b_q      <= val_b_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign valA       = val_a_q;
  assign valB       = val_b_q;
  assign wr_collide = wr_collide_q;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor of the Y86 register file, with configurable data width and register count. It has two synchronous write ports: E from execute and M from memory. It has two registered read ports, A and B, each with one-cycle latency, and a read-hold (stall) input. All register contents are exposed as one flattened debug bus for the bench and top-level display.

Parameters:
DATA_W, 32, width of each register and of every data port.
NREG, 8, number of implemented registers (IDs 0..NREG-1); legal range 1..15.
ID_W, 4, register ID width; ID 4'hF (all ones) is the reserved RNONE code.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
dstE  in  ID_W  E-port destination ID; RNONE or ID>=NREG means no write.
valE  in  DATA_W  E-port write data.
dstM  in  ID_W  M-port destination ID; RNONE or ID>=NREG means no write.
valM  in  DATA_W  M-port write data.
rA  in  ID_W  read port A source ID.
rB  in  ID_W  read port B source ID.
stall  in  1  when high, valA/valB hold; writes still proceed.
valA  out  DATA_W  registered read data, port A.
valB  out  DATA_W  registered read data, port B.
regs_flat  out  NREG*DATA_W  register i at bits [i*DATA_W +: DATA_W]; reflects storage directly, no extra delay.
wr_collide  out  1  registered flag: previous edge had dstE==dstM, both valid.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high, as decided.
- Reset: on an edge with reset=1, every register, valA, valB and wr_collide become 0.
  - Reset dominates all writes, reads and stall on that edge.
  - Reset asserted mid-stream discards any write presented on that edge.
- Write validity: a port writes when its dst < NREG and dst != RNONE. Otherwise it is ignored silently, with no side effects.
- Write commit: writes commit on the rising edge and are visible on regs_flat immediately after that edge.
- Simultaneous writes to different valid IDs: both commit on the same edge.
- Write collision (dstE == dstM, both valid): valM is stored and valE is discarded (M priority, needed for popl %esp). wr_collide=1 on the following cycle only.
- Read latency: one cycle. At edge k, with stall=0, valA <= R[rA] and valB <= R[rB], sampled from storage as it was before edge k's writes.
- Out-of-range read: rA/rB of RNONE or >= NREG loads 0. This replaces the legacy hold-previous behaviour.
- Stall: with stall=1 (and reset=0), valA/valB keep their values; register writes and wr_collide still update.
- rA == rB: both ports return identical data.
- Arithmetic: none. Data is passed through unmodified at DATA_W bits; no truncation or extension inside the block.
- No state machine. State consists of NREG x DATA_W storage, two output registers and one flag register.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: the read data loaded at an edge includes that same edge's writes.
  - If rA matches a valid dstM, valA <= valM.
  - Else if rA matches a valid dstE, valA <= valE.
  - Else valA <= R[rA].
  - Port B follows the same rule. M priority matches the storage collision rule.
  - Stall and out-of-range rules are unchanged.
- Undefined: read data reflects pre-edge storage only, as described in Behaviour.

Test Plan:
- Reset: write 0x1234 to r3, then assert reset for 1 edge -> regs_flat all 0, valA=valB=0, wr_collide=0. Assert reset together with dstE=2, valE=0x55 -> r2 stays 0.
- Dual write and read: dstE=1/valE=0xAAAA0001 and dstM=4/valM=0xBBBB0004 on the same edge; next edge rA=1, rB=4 -> one cycle later valA=0xAAAA0001, valB=0xBBBB0004.
- Collision: dstE=dstM=5, valE=0x11, valM=0x22 -> r5=0x22, wr_collide=1 for exactly one cycle, then 0.
- Invalid IDs: dstE=0xF, dstM=NREG (8) with nonzero data -> regs_flat unchanged. rA=0xF, rB=9 -> valA=valB=0.
- Stall: valA=0x77 held with stall=1 for 3 cycles while rA changes and dstE=rA writes 0x99 -> valA stays 0x77 and r[rA]=0x99. Release stall -> valA=0x99 next edge.
- Read/write same edge: rA=2, dstE=2, valE=0xC0DE, old r2=0x1 -> valA=0x1 without the macro, valA=0xC0DE with REGFILE_WRITE_BYPASS_EN. Run once with NREG=15, DATA_W=64 to check parametrisation.
